// File: rtl/uart_io_unit.sv
// UART I/O engine: RX/TX byte FIFOs, request FSM for IN/OUT/OUTINT and decimal conversion.
// Optional feature macro: OUTINT_SIGNED_EN (OUTINT operand treated as two's-complement).

module uart_io_fifo #(
    parameter int LOG2 = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int DEPTH = 2 ** LOG2;

    logic [7:0]      mem_r [DEPTH];
    logic [LOG2-1:0] wr_ptr_r;
    logic [LOG2-1:0] rd_ptr_r;
    logic [LOG2:0]   count_r;
    logic            push_s;
    logic            pop_s;

    assign full   = (count_r == (LOG2+1)'(DEPTH));
    assign empty  = (count_r == {(LOG2+1){1'b0}});
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Storage array with registered read port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= wdata;
        if (pop_s)  rdata <= mem_r[rd_ptr_r];
    end

    // Pointers wrap naturally; simultaneous push/pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {LOG2{1'b0}};
            rd_ptr_r <= {LOG2{1'b0}};
            count_r  <= {(LOG2+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + LOG2'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + LOG2'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (LOG2+1)'(1);
                2'b01:   count_r <= count_r - (LOG2+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module uart_rx #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic       ready,
    output logic [7:0] rdata
);
    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CW = $clog2(BIT_CYC) + 1;

    logic [1:0]    sync_r;
    logic          active_r;
    logic [3:0]    idx_r;
    logic [CW-1:0] cnt_r;
    logic [7:0]    shift_r;
    logic          tick_s;

    // Start bit waits half a bit to land mid-bit; later bits wait a full bit.
    assign tick_s = (idx_r == 4'd0) ? (cnt_r == CW'(CLK_PER_HALF_BIT - 1))
                                    : (cnt_r == CW'(BIT_CYC - 1));

    // Synchroniser, bit sampler and frame assembler (idx 0 start, 1..8 data, 9 stop).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r   <= 2'b11;
            active_r <= 1'b0;
            idx_r    <= 4'd0;
            cnt_r    <= {CW{1'b0}};
            shift_r  <= 8'h00;
            ready    <= 1'b0;
            rdata    <= 8'h00;
        end else begin
            sync_r <= {sync_r[0], rxd};
            ready  <= 1'b0;
            if (!active_r) begin
                if (!sync_r[1]) begin
                    active_r <= 1'b1;
                    idx_r    <= 4'd0;
                    cnt_r    <= {CW{1'b0}};
                end
            end else if (tick_s) begin
                cnt_r <= {CW{1'b0}};
                if (idx_r == 4'd0) begin
                    if (sync_r[1]) active_r <= 1'b0;
                    else           idx_r <= 4'd1;
                end else if (idx_r == 4'd9) begin
                    active_r <= 1'b0;
                    if (sync_r[1]) begin
                        ready <= 1'b1;
                        rdata <= shift_r;
                    end
                end else begin
                    shift_r <= {sync_r[1], shift_r[7:1]};
                    idx_r   <= idx_r + 4'd1;
                end
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end
endmodule

module uart_tx #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy
);
    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CW = $clog2(BIT_CYC) + 1;

    logic [8:0]    shift_r;
    logic [3:0]    idx_r;
    logic [CW-1:0] cnt_r;

    // Serialiser: start bit, 8 data bits LSB first, stop bit; busy spans the whole frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txd     <= 1'b1;
            busy    <= 1'b0;
            shift_r <= 9'h1FF;
            idx_r   <= 4'd0;
            cnt_r   <= {CW{1'b0}};
        end else if (!busy) begin
            if (start) begin
                busy    <= 1'b1;
                txd     <= 1'b0;
                shift_r <= {1'b1, data};
                idx_r   <= 4'd0;
                cnt_r   <= {CW{1'b0}};
            end
        end else if (cnt_r == CW'(BIT_CYC - 1)) begin
            cnt_r <= {CW{1'b0}};
            if (idx_r == 4'd9) begin
                busy <= 1'b0;
            end else begin
                txd     <= shift_r[0];
                shift_r <= {1'b1, shift_r[8:1]};
                idx_r   <= idx_r + 4'd1;
            end
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end
endmodule

module uart_io_unit #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int RX_LOG2          = 11,
    parameter int TX_LOG2          = 10,
    parameter int INT_W            = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rxd,
    output logic             txd,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [INT_W-1:0] req_data,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [31:0]      rsp_data,
    output logic             rx_overflow,
    output logic             aa_received,
    output logic             tx_empty
);
    // Decimal digits of 2**INT_W-1, i.e. ceil(INT_W*log10(2)).
    localparam int DIGITS = (INT_W * 30103 + 99999) / 100000;
    localparam int IDX_W  = $clog2(DIGITS) + 1;

    typedef enum logic [2:0] {
        IDLE, IN_WAIT, IN_RD, OUT_PUSH, CV_INIT, CV_DIG, CV_PUSH, DONE
    } state_t;

    state_t             state_r, state_next_s;
    logic [1:0]         op_r;
    logic [INT_W-1:0]   data_r;
    logic [INT_W-1:0]   rem_r;
    logic [INT_W-1:0]   p_s;
    logic [IDX_W-1:0]   idx_r;
    logic [3:0]         digit_r;
    logic               seen_r;
    logic               emit_s;
    logic               accept_s;
    logic               rx_ready_s, rx_full_s, rx_empty_s, rx_pop_s;
    logic [7:0]         rx_byte_s, rx_rdata_s;
    logic               tx_push_s, tx_pop_s, tx_full_s, tx_fifo_empty_s, tx_busy_s;
    logic [7:0]         tx_wdata_s, tx_rdata_s;
    logic               tx_start_r;
    logic               req_ready_r, rsp_valid_r, rx_overflow_r, aa_r, tx_empty_r;
    logic [31:0]        rsp_data_r;

    function automatic logic [INT_W-1:0] pow10(input logic [IDX_W-1:0] k);
        logic [INT_W-1:0] p;
        p = INT_W'(1);
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (i < int'(k)) p = p * INT_W'(10);
            else             p = p;
        end
        return p;
    endfunction

    assign p_s      = pow10(idx_r);
    assign emit_s   = (digit_r != 4'd0) || seen_r || (idx_r == {IDX_W{1'b0}});
    assign accept_s = req_valid && req_ready_r && (state_r == IDLE);
    assign tx_pop_s = !tx_busy_s && !tx_start_r && !tx_fifo_empty_s;

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rx_overflow = rx_overflow_r;
    assign aa_received = aa_r;
    assign tx_empty    = tx_empty_r;

    uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
        .clk(clk), .rstn(rstn), .rxd(rxd), .ready(rx_ready_s), .rdata(rx_byte_s));

    uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
        .clk(clk), .rstn(rstn), .start(tx_start_r), .data(tx_rdata_s), .txd(txd), .busy(tx_busy_s));

    uart_io_fifo #(.LOG2(RX_LOG2)) u_rx_fifo (
        .clk(clk), .rstn(rstn), .push(rx_ready_s), .pop(rx_pop_s), .wdata(rx_byte_s),
        .rdata(rx_rdata_s), .full(rx_full_s), .empty(rx_empty_s));

    uart_io_fifo #(.LOG2(TX_LOG2)) u_tx_fifo (
        .clk(clk), .rstn(rstn), .push(tx_push_s), .pop(tx_pop_s), .wdata(tx_wdata_s),
        .rdata(tx_rdata_s), .full(tx_full_s), .empty(tx_fifo_empty_s));

    // Request FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_r <= IDLE;
        else       state_r <= state_next_s;
    end

    // Next-state logic plus FIFO push/pop strobes.
    always_comb begin
        state_next_s = state_r;
        rx_pop_s     = 1'b0;
        tx_push_s    = 1'b0;
        tx_wdata_s   = 8'h00;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (req_op)
                        2'b00:   state_next_s = IN_WAIT;
                        2'b01:   state_next_s = OUT_PUSH;
                        2'b10:   state_next_s = CV_INIT;
                        default: state_next_s = DONE;
                    endcase
                end else begin
                    state_next_s = IDLE;
                end
            end
            IN_WAIT: begin
                if (!rx_empty_s) begin
                    rx_pop_s     = 1'b1;
                    state_next_s = IN_RD;
                end else begin
                    state_next_s = IN_WAIT;
                end
            end
            IN_RD: state_next_s = DONE;
            OUT_PUSH: begin
                if (!tx_full_s) begin
                    tx_push_s    = 1'b1;
                    tx_wdata_s   = data_r[7:0];
                    state_next_s = DONE;
                end else begin
                    state_next_s = OUT_PUSH;
                end
            end
            CV_INIT: begin
`ifdef OUTINT_SIGNED_EN
                // The minus sign must be queued before any digit, so wait for room.
                if (data_r[INT_W-1]) begin
                    if (!tx_full_s) begin
                        tx_push_s    = 1'b1;
                        tx_wdata_s   = 8'h2D;
                        state_next_s = CV_DIG;
                    end else begin
                        state_next_s = CV_INIT;
                    end
                end else begin
                    state_next_s = CV_DIG;
                end
`else
                state_next_s = CV_DIG;
`endif
            end
            CV_DIG: begin
                if (rem_r >= p_s) state_next_s = CV_DIG;
                else              state_next_s = CV_PUSH;
            end
            CV_PUSH: begin
                if (!tx_full_s) begin
                    tx_push_s    = emit_s;
                    tx_wdata_s   = 8'h30 + {4'h0, digit_r};
                    state_next_s = (idx_r == {IDX_W{1'b0}}) ? DONE : CV_DIG;
                end else begin
                    state_next_s = CV_PUSH;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand latch and repeated-subtraction decimal conversion datapath.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_r    <= 2'b00;
            data_r  <= {INT_W{1'b0}};
            rem_r   <= {INT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            digit_r <= 4'd0;
            seen_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r   <= req_op;
                        data_r <= req_data;
                    end
                end
                CV_INIT: begin
`ifdef OUTINT_SIGNED_EN
                    rem_r <= data_r[INT_W-1] ? (~data_r + INT_W'(1)) : data_r;
`else
                    rem_r <= data_r;
`endif
                    idx_r   <= IDX_W'(DIGITS - 1);
                    digit_r <= 4'd0;
                    seen_r  <= 1'b0;
                end
                CV_DIG: begin
                    if (rem_r >= p_s) begin
                        rem_r   <= rem_r - p_s;
                        digit_r <= digit_r + 4'd1;
                    end
                end
                CV_PUSH: begin
                    if (!tx_full_s) begin
                        seen_r  <= seen_r || (digit_r != 4'd0);
                        digit_r <= 4'd0;
                        if (idx_r != {IDX_W{1'b0}}) idx_r <= idx_r - IDX_W'(1);
                    end
                end
                default: op_r <= op_r;
            endcase
        end
    end

    // Handshake, response, status flags and TX drain sequencing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 32'h0000_0000;
            rx_overflow_r <= 1'b0;
            aa_r          <= 1'b0;
            tx_start_r    <= 1'b0;
            tx_empty_r    <= 1'b1;
        end else begin
            rsp_valid_r <= (state_r == DONE);
            if (state_r == DONE)
                rsp_data_r <= (op_r == 2'b00) ? {24'h00_0000, rx_rdata_s} : 32'h0000_0000;
            if (accept_s)         req_ready_r <= 1'b0;
            else if (rsp_valid_r) req_ready_r <= 1'b1;
            if (rx_ready_s && rx_full_s) rx_overflow_r <= 1'b1;
            aa_r       <= rx_ready_s && (rx_byte_s == 8'hAA);
            tx_start_r <= tx_pop_s;
            tx_empty_r <= tx_fifo_empty_s && !tx_busy_s && !tx_start_r && !tx_push_s;
        end
    end
endmodule

// File: tb/tb_uart_io_unit.sv
// Directed, scoreboard-based bench for uart_io_unit with shrunken FIFOs and a fast baud rate.
module tb_uart_io_unit;
    localparam int HB = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rxd = 1'b1;
    logic        txd;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_data = 32'h0;
    logic        req_ready, rsp_valid, rx_overflow, aa_received, tx_empty;
    logic [31:0] rsp_data;

    int n_assert = 0;
    int n_fail = 0;
    int aa_cnt = 0;
    int epoch = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    uart_io_unit #(.CLK_PER_HALF_BIT(HB), .RX_LOG2(2), .TX_LOG2(2), .INT_W(32)) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rx_overflow(rx_overflow), .aa_received(aa_received), .tx_empty(tx_empty));

    always #5 clk = ~clk;
    always @(posedge clk) if (aa_received === 1'b1) aa_cnt++;
    always @(negedge rstn) epoch++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit kept);
        if (kept) rx_q.push_back(b);
        rxd = 1'b0;
        repeat (2 * HB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (2 * HB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (2 * HB) @(negedge clk);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] data, input int exp_lat, output int lat);
        int t;
        logic [31:0] exp_rsp;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20000) begin @(negedge clk); t++; end
        chk("req_ready_wait", 32'(t < 20000), 32'd1);
        req_valid = 1'b1; req_op = op; req_data = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 20000) begin @(posedge clk); #1; lat++; end
        chk("rsp_timeout", 32'(lat < 20000), 32'd1);
        if (exp_lat >= 0) chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("ready_low_at_rsp", {31'd0, req_ready}, 32'd0);
        exp_rsp = 32'h0;
        if (op == 2'b00) exp_rsp = (rx_q.size() > 0) ? {24'h0, rx_q.pop_front()} : 32'hDEAD_BEEF;
        chk("rsp_data", rsp_data, exp_rsp);
        @(posedge clk); #1;
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("ready_after_rsp", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((tx_q.size() != 0 || !tx_empty) && t < 30000) begin @(negedge clk); t++; end
        chk({tag, "_queue"}, 32'(tx_q.size()), 32'd0);
        chk({tag, "_tx_empty"}, {31'd0, tx_empty}, 32'd1);
    endtask

    // TX line monitor: decodes frames and pops the expected byte scoreboard.
    initial begin
        logic [7:0] b;
        logic [8:0] exp_b;
        logic       sb, stp;
        int         ep;
        wait (rstn === 1'b1);
        forever begin
            @(negedge txd);
            ep = epoch;
            repeat (HB) @(negedge clk);
            sb = txd;
            for (int i = 0; i < 8; i++) begin
                repeat (2 * HB) @(negedge clk);
                b[i] = txd;
            end
            repeat (2 * HB) @(negedge clk);
            stp = txd;
            if (ep == epoch && rstn === 1'b1) begin
                chk("tx_start_bit", {31'd0, sb}, 32'd0);
                chk("tx_stop_bit", {31'd0, stp}, 32'd1);
                exp_b = (tx_q.size() > 0) ? {1'b0, tx_q.pop_front()} : 9'h100;
                chk("tx_byte", {24'h0, b}, {23'h0, exp_b});
            end
        end
    end

    initial begin
        int lat, max_lat, t, aa0, lows;
        repeat (5) @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
        chk("rst_aa", {31'd0, aa_received}, 32'd0);
        chk("rst_tx_empty", {31'd0, tx_empty}, 32'd1);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single OUT
        tx_q.push_back(8'h41);
        do_req(2'b01, 32'h41, 2, lat);
        wait_drain("out41");

        // 2: two received bytes, one of them 0xAA
        aa0 = aa_cnt;
        send_byte(8'h12, 1'b1);
        send_byte(8'hAA, 1'b1);
        repeat (10) @(negedge clk);
        chk("aa_pulse_count", 32'(aa_cnt - aa0), 32'd1);
        do_req(2'b00, 32'h0, 3, lat);
        do_req(2'b00, 32'h0, 3, lat);

        // 3: IN waits for a late byte
        fork
            begin repeat (40) @(negedge clk); send_byte(8'h7F, 1'b1); end
        join_none
        do_req(2'b00, 32'h0, -1, lat);
        chk("in_wait_long", 32'(lat > 40), 32'd1);
        repeat (100) @(negedge clk);

        // reserved op answers next cycle with zero data
        do_req(2'b11, 32'hFFFF_FFFF, 1, lat);

        // 4: OUTINT conversions
        push_str("0");
        do_req(2'b10, 32'd0, -1, lat);
        push_str("105");
        do_req(2'b10, 32'd105, -1, lat);
        push_str("4294967295");
        do_req(2'b10, 32'hFFFF_FFFF, -1, lat);
`ifdef OUTINT_SIGNED_EN
        push_str("-123");
`else
        push_str("4294967173");
`endif
        do_req(2'b10, 32'hFFFF_FF85, -1, lat);
        wait_drain("outint");

        // 5: RX overflow with a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_byte(8'(i), i <= 4);
        repeat (10) @(negedge clk);
        chk("rx_overflow_set", {31'd0, rx_overflow}, 32'd1);
        for (int i = 0; i < 4; i++) do_req(2'b00, 32'h0, 3, lat);
        chk("rx_overflow_sticky", {31'd0, rx_overflow}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rx_overflow_reset", {31'd0, rx_overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // 6: back-to-back OUTs against a 4-deep TX FIFO
        max_lat = 0;
        for (int i = 0; i < 6; i++) begin
            tx_q.push_back(8'hA0 + 8'(i));
            do_req(2'b01, 32'hA0 + 32'(i), -1, lat);
            if (lat > max_lat) max_lat = lat;
        end
        chk("tx_full_stall", 32'(max_lat > 2), 32'd1);
        wait_drain("b2b");

        // reset in the middle of a frame aborts it and discards queued bytes
        do_req(2'b01, 32'h55, 2, lat);
        do_req(2'b01, 32'h66, 2, lat);
        t = 0;
        while (txd && t < 1000) begin @(negedge clk); t++; end
        chk("frame_started", 32'(t < 1000), 32'd1);
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_txd", {31'd0, txd}, 32'd1);
        chk("abort_tx_empty", {31'd0, tx_empty}, 32'd1);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk("no_tx_after_reset", 32'(lows), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
